// File: rtl/hyperbus_target.sv
// ---------------------------------------------------------------------------
// hyperbus_target
//
// HyperBus follower that answers a HyperBus leader. It works on the leader's
// DDR-split view of the bus: each clk carries one 2*WIDTH-bit word, and
// dq/rwds have already gone through the I/O DDR cells.
//
// A transaction runs as follows:
//   1. The 48-bit command/address (CA) arrives as three 16-bit beats.
//   2. The initial latency is counted down.
//   3. Read data streams out with RWDS strobes, or masked write data is
//      applied to memory.
// Transactions go to a synchronous SRAM port with 1-cycle read latency, or
// to the internal ID0/CR0 registers.
//
// Ports
//   clk          memory clock, shared with the leader
//   rst          asynchronous reset, active high
//   hb_csn_i     chip select, active low
//   hb_dq_i      CA / write data word ([15:8] = first edge)
//   hb_dq_o      read data word
//   hb_dq_oe     DQ output enable
//   hb_rwds_i    write mask, 1 = byte masked, [1] = first edge
//   hb_rwds_o    latency flag during CA, read strobe during READ
//   hb_rwds_oe   RWDS output enable
//   mem_adr_o    word address to the SRAM port
//   mem_re_o     read strobe; mem_dat_i is valid on the following clk
//   mem_we_o     write strobe
//   mem_be_o     byte enables for mem_dat_o
//   mem_dat_o    write data
//   mem_dat_i    read data
//   cr0_o        current CR0 value
//   err_o        one-clk pulse when csn rises before the CA is complete
//
// CA decode assumes WIDTH >= 8; the CA and the registers are 16 bits wide.
// ---------------------------------------------------------------------------
module hyperbus_target #(
    parameter int          WIDTH       = 8,
    parameter int          ADDR_LENGTH = 32,
    parameter int          TACC_COUNT  = 5,
    parameter int          DOUBLE_LAT  = 0,
    parameter logic [15:0] ID0_VAL     = 16'h0C81,
    parameter logic [15:0] CR0_RST     = 16'h8F1F
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hb_csn_i,
    input  logic [2*WIDTH-1:0]     hb_dq_i,
    output logic [2*WIDTH-1:0]     hb_dq_o,
    output logic                   hb_dq_oe,
    input  logic [1:0]             hb_rwds_i,
    output logic [1:0]             hb_rwds_o,
    output logic                   hb_rwds_oe,
    output logic [ADDR_LENGTH-1:0] mem_adr_o,
    output logic                   mem_re_o,
    output logic                   mem_we_o,
    output logic [1:0]             mem_be_o,
    output logic [2*WIDTH-1:0]     mem_dat_o,
    input  logic [2*WIDTH-1:0]     mem_dat_i,
    output logic [15:0]            cr0_o,
    output logic                   err_o
);

    localparam int DW    = 2 * WIDTH;
    localparam int LAT_W = 8;
    localparam logic [LAT_W-1:0]       LAT_LOAD = LAT_W'(TACC_COUNT << DOUBLE_LAT);
    localparam logic [1:0]             LAT_FLAG = (DOUBLE_LAT != 0) ? 2'b11 : 2'b00;
    localparam logic [ADDR_LENGTH-1:0] CR0_ADR  = ADDR_LENGTH'(32'h800);
    localparam logic [ADDR_LENGTH-1:0] ADR_ONE  = ADDR_LENGTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LATENCY,
        ST_READ,
        ST_WRITE
    } state_t;

    state_t                 state_reg;
    logic [1:0]             beat_reg;
    logic                   rw_reg;        // 1 = read
    logic                   as_reg;        // 1 = register space
    logic [12:0]            ca_row_reg;    // CA[44:32]
    logic [15:0]            ca_mid_reg;    // CA[31:16]
    logic [ADDR_LENGTH-1:0] addr_reg;
    logic [LAT_W-1:0]       lat_reg;
    logic                   dq_oe_reg;
    logic                   rwds_oe_reg;
    logic [1:0]             rwds_o_reg;
    logic [DW-1:0]          reg_dat_reg;
    logic                   err_reg;

    logic [31:0]            ca_addr;
    logic [DW-1:0]          reg_rd_val;
    logic                   cr0_wr;
    logic [1:0]             lane_en;

    // The third CA beat is still on hb_dq_i when the address is assembled.
    // CA[15:3] is reserved and is not used.
    assign ca_addr = {ca_row_reg, ca_mid_reg, hb_dq_i[2:0]};

    always_comb begin
        reg_rd_val = '0;
        if (addr_reg == '0) begin
            reg_rd_val = DW'(ID0_VAL);
        end else if (addr_reg == CR0_ADR) begin
            reg_rd_val = DW'(cr0_o);
        end
    end

    // CR0 keeps one register per byte lane, so each unmasked byte updates
    // independently of the other.
    assign lane_en = ~hb_rwds_i;
    assign cr0_wr  = (state_reg == ST_WRITE) && !hb_csn_i && as_reg && (addr_reg == CR0_ADR);

    for (genvar gi = 0; gi < 2; gi++) begin : g_cr0_lane
        logic [7:0] lane_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lane_reg <= CR0_RST[gi*8 +: 8];
            end else if (cr0_wr && lane_en[gi]) begin
                lane_reg <= hb_dq_i[gi*8 +: 8];
            end
        end
    end

    assign cr0_o = {g_cr0_lane[1].lane_reg, g_cr0_lane[0].lane_reg};

    // Main transaction FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            beat_reg    <= 2'd0;
            rw_reg      <= 1'b0;
            as_reg      <= 1'b0;
            ca_row_reg  <= '0;
            ca_mid_reg  <= '0;
            addr_reg    <= '0;
            lat_reg     <= '0;
            dq_oe_reg   <= 1'b0;
            rwds_oe_reg <= 1'b0;
            rwds_o_reg  <= 2'b00;
            reg_dat_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!hb_csn_i) begin
                        rw_reg      <= hb_dq_i[15];
                        as_reg      <= hb_dq_i[14];
                        ca_row_reg  <= hb_dq_i[12:0];
                        beat_reg    <= 2'd1;
                        rwds_oe_reg <= 1'b1;
                        rwds_o_reg  <= LAT_FLAG;
                        state_reg   <= ST_CA;
                    end
                end
                ST_CA: begin
                    if (hb_csn_i) begin
                        // The CA was cut short.
                        err_reg     <= 1'b1;
                        rwds_oe_reg <= 1'b0;
                        rwds_o_reg  <= 2'b00;
                        state_reg   <= ST_IDLE;
                    end else if (beat_reg == 2'd1) begin
                        ca_mid_reg <= hb_dq_i[15:0];
                        beat_reg   <= 2'd2;
                    end else begin
                        addr_reg    <= ADDR_LENGTH'(ca_addr);
                        lat_reg     <= LAT_LOAD;
                        rwds_oe_reg <= 1'b0;
                        rwds_o_reg  <= 2'b00;
                        // Register writes carry no latency phase.
                        state_reg   <= (!rw_reg && as_reg) ? ST_WRITE : ST_LATENCY;
                    end
                end
                ST_LATENCY: begin
                    if (hb_csn_i) begin
                        state_reg <= ST_IDLE;
                    end else if (lat_reg != '0) begin
                        lat_reg <= lat_reg - LAT_W'(1);
                    end else if (rw_reg) begin
                        // The prefetch issued at lat==1 used addr_reg, so
                        // the next fetch address is one word beyond it.
                        dq_oe_reg   <= 1'b1;
                        rwds_oe_reg <= 1'b1;
                        rwds_o_reg  <= 2'b10;
                        reg_dat_reg <= reg_rd_val;
                        addr_reg    <= addr_reg + ADR_ONE;
                        state_reg   <= ST_READ;
                    end else begin
                        state_reg <= ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (hb_csn_i) begin
                        dq_oe_reg   <= 1'b0;
                        rwds_oe_reg <= 1'b0;
                        rwds_o_reg  <= 2'b00;
                        state_reg   <= ST_IDLE;
                    end else begin
                        reg_dat_reg <= reg_rd_val;
                        addr_reg    <= addr_reg + ADR_ONE;
                    end
                end
                ST_WRITE: begin
                    if (hb_csn_i) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        // The address advances even when both bytes are
                        // masked.
                        addr_reg <= addr_reg + ADR_ONE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Memory-space read data comes straight from the SRAM output register,
    // which the lat==1 prefetch has already lined up with the first beat.
    assign hb_dq_o    = dq_oe_reg ? (as_reg ? reg_dat_reg : mem_dat_i) : '0;
    assign hb_dq_oe   = dq_oe_reg;
    assign hb_rwds_o  = rwds_o_reg;
    assign hb_rwds_oe = rwds_oe_reg;
    assign err_o      = err_reg;

    // The strobes are gated by the live chip select, so a clk with csn high
    // never reaches memory.
    assign mem_adr_o = addr_reg;
    assign mem_re_o  = !hb_csn_i && rw_reg && !as_reg &&
                       (((state_reg == ST_LATENCY) && (lat_reg == LAT_W'(1))) ||
                        (state_reg == ST_READ));
    assign mem_we_o  = !hb_csn_i && (state_reg == ST_WRITE) && !as_reg &&
                       (hb_rwds_i != 2'b11);
    assign mem_be_o  = mem_we_o ? ~hb_rwds_i : 2'b00;
    assign mem_dat_o = hb_dq_i;

endmodule
